// File: rtl/hls_run_sequencer_if.sv
// Bundle of command, DUT-control, slave-RAM and result signals for hls_run_sequencer.
// master: sequencer side (takes commands, drives the Bambu top and the slave RAM port,
//         returns result records).
// slave : environment side (issues commands, models the Bambu top, consumes results).
interface hls_run_sequencer_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ERR_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              start_port;
  logic              done_port;
  logic              S_oe_ram;
  logic              S_we_ram;
  logic [ADDR_W-1:0] S_addr_ram;
  logic [DATA_W-1:0] S_Wdata_ram;
  logic [7:0]        S_data_ram_size;
  logic [DATA_W-1:0] Sout_Rdata_ram;
  logic              Sout_DataRdy;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_status;
  logic [CNT_W-1:0]  res_cycles;
  logic [ERR_W-1:0]  res_errors;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, done_port, Sout_Rdata_ram, Sout_DataRdy,
           res_ready,
    output cmd_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
           S_data_ram_size, res_valid, res_status, res_cycles, res_errors
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, done_port, Sout_Rdata_ram, Sout_DataRdy,
           res_ready,
    input  cmd_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
           S_data_ram_size, res_valid, res_status, res_cycles, res_errors
  );
endinterface

// File: rtl/hls_run_sequencer.sv
// Command-driven harness around a Bambu-generated top: preloads memory through the slave
// RAM port (WRITE), starts the DUT and measures start->done latency (RUN), reads memory
// back against expected words (CHECK), and emits a result record (REPORT).
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   bus   - hls_run_sequencer_if.master: cmd_*, start/done, S_* slave RAM port, res_*
module hls_run_sequencer #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200000000,
  parameter int unsigned ERR_W   = 16
) (
  input logic                 clock,
  input logic                 reset,
  hls_run_sequencer_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMemWr  = 3'd1;
  localparam logic [2:0] StMemRd  = 3'd2;
  localparam logic [2:0] StStart  = 3'd3;
  localparam logic [2:0] StRun    = 3'd4;
  localparam logic [2:0] StReport = 3'd5;

  localparam logic [1:0] OpWrite  = 2'b00;
  localparam logic [1:0] OpRun    = 2'b01;
  localparam logic [1:0] OpCheck  = 2'b10;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
  logic [ERR_W-1:0]  errors_q, errors_d;
  logic              checked_q, checked_d;
  logic              timed_out_q, timed_out_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              tmo_hit;
  logic              mem_active;
  logic [1:0]        status;

  // Saturating increment shared by run latency and memory-access timeout.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = (cnt_inc >= TimeoutCnt);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    res_cycles_d = res_cycles_q;
    errors_d     = errors_q;
    checked_d    = checked_q;
    timed_out_d  = timed_out_q;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d = bus.cmd_addr;
          data_d = bus.cmd_data;
          cnt_d  = '0;
          case (bus.cmd_op)
            OpWrite: state_d = StMemWr;
            OpRun:   state_d = StStart;
            OpCheck: state_d = StMemRd;
            default: state_d = StReport;
          endcase
        end
      end
      StMemWr, StMemRd: begin
        if (bus.Sout_DataRdy) begin
          if (state_q == StMemRd) begin
            if ((bus.Sout_Rdata_ram != data_q) && (errors_q != '1)) begin
              errors_d = errors_q + 1'b1;
            end
            checked_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) begin
            timed_out_d  = 1'b1;
            res_cycles_d = TimeoutCnt;
            state_d      = StIdle;
          end
        end
      end
      StStart: begin
        // Start cycle counts as cycle 1 of the latency.
        cnt_d = CNT_W'(1);
        if (bus.done_port) begin
          res_cycles_d = CNT_W'(1);
          state_d      = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (bus.done_port) begin
          res_cycles_d = cnt_inc;
          state_d      = StIdle;
        end else if (tmo_hit) begin
          timed_out_d  = 1'b1;
          res_cycles_d = TimeoutCnt;
          state_d      = StIdle;
        end
      end
      StReport: begin
        if (bus.res_ready) begin
          errors_d    = '0;
          checked_d   = 1'b0;
          timed_out_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered so cmd_ready stays low while reset is asserted.
  assign cmd_ready_d = (state_d == StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      res_cycles_q <= '0;
      errors_q     <= '0;
      checked_q    <= 1'b0;
      timed_out_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      res_cycles_q <= res_cycles_d;
      errors_q     <= errors_d;
      checked_q    <= checked_d;
      timed_out_q  <= timed_out_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  always_comb begin
    if (timed_out_q)          status = 2'b10;
    else if (errors_q != '0)  status = 2'b01;
    else if (!checked_q)      status = 2'b11;
    else                      status = 2'b00;
  end

  assign mem_active          = (state_q == StMemWr) || (state_q == StMemRd);
  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.start_port      = (state_q == StStart);
  assign bus.S_we_ram        = (state_q == StMemWr);
  assign bus.S_oe_ram        = (state_q == StMemRd);
  assign bus.S_addr_ram      = mem_active ? addr_q : '0;
  assign bus.S_Wdata_ram     = (state_q == StMemWr) ? data_q : '0;
  assign bus.S_data_ram_size = mem_active ? 8'(DATA_W) : 8'd0;
  assign bus.res_valid       = (state_q == StReport);
  assign bus.res_status      = (state_q == StReport) ? status : 2'b00;
  assign bus.res_cycles      = res_cycles_q;
  assign bus.res_errors      = errors_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer: REPORT commands push expected result records,
// a monitor pops and compares on every result handshake. Slave RAM and DUT-done are
// modelled with programmable response delays.
module tb_hls_run_sequencer;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned ERR_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  localparam logic [1:0] OpWrite  = 2'b00;
  localparam logic [1:0] OpRun    = 2'b01;
  localparam logic [1:0] OpCheck  = 2'b10;
  localparam logic [1:0] OpReport = 2'b11;

  typedef struct packed {
    logic [1:0]       status;
    logic [CNT_W-1:0] cycles;
    logic [ERR_W-1:0] errors;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hls_run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  hls_run_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave RAM model: DataRdy after rdy_delay strobe cycles.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int unsigned rdy_delay = 2;
  int unsigned rdy_cnt   = 0;
  always @(posedge clock) begin
    if (bus.S_we_ram || bus.S_oe_ram) rdy_cnt <= rdy_cnt + 1;
    else                              rdy_cnt <= 0;
    if (bus.S_we_ram && bus.Sout_DataRdy) mem[bus.S_addr_ram] <= bus.S_Wdata_ram;
  end
  assign bus.Sout_DataRdy   = (bus.S_we_ram || bus.S_oe_ram) && (rdy_cnt == rdy_delay);
  assign bus.Sout_Rdata_ram = bus.S_oe_ram ? mem[bus.S_addr_ram] : '0;

  // DUT model: done_port at cycle done_at after start (start is cycle 0); 0 = never.
  int unsigned done_at = 0;
  int unsigned run_cnt = 0;
  always @(posedge clock) begin
    if (bus.start_port)    run_cnt <= 1;
    else if (run_cnt != 0) run_cnt <= run_cnt + 1;
  end
  assign bus.done_port = (done_at != 0) && (run_cnt == done_at);

  // Scoreboard monitor.
  res_t sb_q[$];
  res_t mon_exp;
  always @(negedge clock) begin
    if (reset && bus.res_valid && bus.res_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(bus.res_status), 64'hFFFF);
      end else begin
        mon_exp = sb_q.pop_front();
        check("res_status", 64'(bus.res_status), 64'(mon_exp.status));
        check("res_cycles", 64'(bus.res_cycles), 64'(mon_exp.cycles));
        check("res_errors", 64'(bus.res_errors), 64'(mon_exp.errors));
      end
    end
  end

  task automatic push_exp(input logic [1:0] st, input int unsigned cyc, input int unsigned err);
    res_t r;
    r.status = st;
    r.cycles = CNT_W'(cyc);
    r.errors = ERR_W'(err);
    sb_q.push_back(r);
  endtask

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    int n = 0;
    @(negedge clock);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("cmd_ready_wait_expired", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Per-command observation of strobes while the sequencer is busy.
  int busy, we_cnt, oe_cnt, st_cnt, bad_bus;
  task automatic wait_idle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    busy = 0; we_cnt = 0; oe_cnt = 0; st_cnt = 0; bad_bus = 0;
    forever begin
      @(negedge clock);
      if (bus.cmd_ready) break;
      busy++;
      if (bus.S_we_ram) we_cnt++;
      if (bus.S_oe_ram) oe_cnt++;
      if (bus.start_port) st_cnt++;
      if ((bus.S_we_ram || bus.S_oe_ram) &&
          (bus.S_addr_ram != a || bus.S_data_ram_size != 8'(DATA_W))) bad_bus++;
      if (bus.S_we_ram && bus.S_Wdata_ram != d) bad_bus++;
      if (!(bus.S_we_ram || bus.S_oe_ram) &&
          (bus.S_addr_ram != '0 || bus.S_data_ram_size != 8'd0)) bad_bus++;
      if (busy >= 1000) begin
        check("idle_wait_expired", 64'(busy), 64'd0);
        break;
      end
    end
  endtask

  function automatic logic outs_any();
    return |{bus.cmd_ready, bus.start_port, bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram,
             bus.S_Wdata_ram, bus.S_data_ram_size, bus.res_valid, bus.res_status,
             bus.res_cycles, bus.res_errors};
  endfunction

  task automatic async_reset(input string name);
    #2 reset = 1'b0;
    #1 check({name, "_outputs_zero"}, 64'(outs_any()), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check({name, "_cmd_ready_after"}, 64'(bus.cmd_ready), 64'd1);
    check({name, "_no_res_valid"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;

    // Reset state.
    #2 check("reset_outputs_zero", 64'(outs_any()), 64'd0);
    repeat (3) @(negedge clock);
    check("reset_held_outputs_zero", 64'(outs_any()), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // WRITE with DataRdy on the third strobe cycle.
    send(OpWrite, 14'h0010, 16'hBEEF);
    wait_idle(14'h0010, 16'hBEEF);
    check("write_we_cycles", 64'(we_cnt), 64'd3);
    check("write_bus_stable", 64'(bad_bus), 64'd0);
    check("write_no_other_strobe", 64'(oe_cnt + st_cnt), 64'd0);

    // RUN with done at the 5th cycle after start.
    done_at = 5;
    send(OpRun, '0, '0);
    wait_idle('0, '0);
    check("run_start_pulse", 64'(st_cnt), 64'd1);
    check("run_busy_cycles", 64'(busy), 64'd6);
    check("run_no_slave_access", 64'(we_cnt + oe_cnt + bad_bus), 64'd0);
    push_exp(2'b11, 6, 0);
    send(OpReport, '0, '0);
    wait_idle('0, '0);

    // Two CHECKs, one mismatching.
    send(OpWrite, 14'h0012, 16'h0002);
    wait_idle(14'h0012, 16'h0002);
    send(OpCheck, 14'h0010, 16'hBEEF);
    wait_idle(14'h0010, 16'hBEEF);
    check("check_oe_cycles", 64'(oe_cnt), 64'd3);
    check("check_bus_stable", 64'(bad_bus), 64'd0);
    send(OpCheck, 14'h0012, 16'h0001);
    wait_idle(14'h0012, 16'h0001);
    push_exp(2'b01, 6, 1);
    send(OpReport, '0, '0);
    wait_idle('0, '0);
    push_exp(2'b11, 6, 0);
    send(OpReport, '0, '0);
    wait_idle('0, '0);

    // RUN timeout.
    done_at = 0;
    send(OpRun, '0, '0);
    wait_idle('0, '0);
    check("timeout_busy_cycles", 64'(busy), 64'd20);
    check("timeout_start_pulse", 64'(st_cnt), 64'd1);
    push_exp(2'b10, 20, 0);
    send(OpReport, '0, '0);
    wait_idle('0, '0);

    // Result back-pressure with a competing command offered.
    bus.res_ready = 1'b0;
    push_exp(2'b11, 20, 0);
    send(OpReport, '0, '0);
    bus.cmd_op    = OpReport;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_res_valid", 64'(bus.res_valid), 64'd1);
      check("stall_res_status", 64'(bus.res_status), 64'd3);
      check("stall_res_cycles", 64'(bus.res_cycles), 64'd20);
      check("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle('0, '0);
    check("stall_handshake_busy", 64'(busy), 64'd1);

    // Async reset mid-RUN.
    done_at = 0;
    send(OpRun, '0, '0);
    repeat (3) @(negedge clock);
    async_reset("reset_mid_run");

    // Async reset mid-MEM_RD.
    rdy_delay = 10;
    send(OpCheck, 14'h0010, 16'h0000);
    repeat (3) @(negedge clock);
    check("mid_rd_oe_active", 64'(bus.S_oe_ram), 64'd1);
    async_reset("reset_mid_rd");
    rdy_delay = 2;

    // Reset cleared flags, errors and the latency record.
    push_exp(2'b11, 0, 0);
    send(OpReport, '0, '0);
    wait_idle('0, '0);

    repeat (2) @(negedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
